r200id_pipe: RTL and testbench
==============================

# r200id_pipe

Parametrised, pipelined successor to the r200 instruction-decode stage. Accepts one fetched instruction per cycle over a valid/ready handshake, reads the general-purpose register file, generates immediates and control, and registers the result into an ID/EX pipeline register. Adds load-use hazard stalling, flush, and an illegal-opcode flag. Sits between the fetch stage and the execute stage; writeback drives the register-file write port.

## Interface
- `XLEN`, 32: datapath width (32 or 64); immediates sign-extend to `XLEN`.
- `NREG`, 32: architectural registers (16 or 32); `RA_W = $clog2(NREG)`.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1 / `in_ready` out 1: fetch handshake.
- `in_pc` in XLEN: PC of `in_instrn`.
- `in_instrn` in 32: instruction.
- `flush` in 1: kill held and incoming instruction.
- `wb_en` in 1, `wb_addr` in RA_W, `wb_data` in XLEN: register-file write port.
- `out_valid` out 1 / `out_ready` in 1: execute handshake.
- `out_pc`, `out_op1`, `out_op2`, `out_rs2v`, `out_brtarg` out XLEN each.
- `out_rdaddr` out RA_W.
- `out_funct3` out 3.
- `out_regwr`, `out_memwr`, `out_isbr`, `out_willjmp`, `out_alu_cont`, `out_illegal` out 1 each.
- `out_wbsel` out 2: 00 ALU, 01 MEM, 10 PC+4.

## Operation
- **Decode by opcode:**
  - OP (0110011): op1=rs1, op2=rs2, regwr.
  - OP-IMM (0010011): op1=rs1, op2=I-imm, regwr.
  - LOAD (0000011): op1=rs1, op2=I-imm, regwr, wbsel=01.
  - STORE (0100011): op1=rs1, op2=S-imm, `out_rs2v`=rs2, memwr.
  - BRANCH (1100011): op1=rs1, op2=rs2, isbr, brtarg=pc+B-imm.
  - LUI (0110111): op1=U-imm, op2=0, regwr.
  - JAL (1101111): willjmp, regwr, wbsel=10, brtarg=pc+J-imm.
  - JALR (1100111): op1=rs1, op2=I-imm, willjmp, regwr, wbsel=10; target is computed in EX.
  - Any other opcode: all controls 0, `out_illegal`=1, and the instruction is still passed downstream with `out_valid`=1.
- `out_alu_cont` = `instrn[30]` for OP, and for OP-IMM with funct3=101; 0 otherwise. `out_funct3` = `instrn[14:12]`.
- `out_rdaddr` = `instrn[11:7]` truncated to RA_W. `out_regwr` is forced to 0 when rd=0.
- Register file:
  - x0 reads as 0 and ignores writes.
  - Reads are combinational and land in the stage register.
  - The PC adders wrap modulo 2^XLEN.
- **Load-use hazard:** a held valid LOAD with rd≠0 whose rd matches the incoming rs1, or the incoming rs2 (OP/STORE/BRANCH only), sets `hazard`.
- **Handshake:**
  - `advance = !out_valid || out_ready`.
  - `in_ready = advance && !hazard && !flush`.
  - On `advance`, the stage loads the input when `in_valid && in_ready`; otherwise it loads a bubble (`out_valid`=0).
- **Flush:** next cycle `out_valid`=0. Flush has priority over everything else, including a hazard.
- Outputs are held stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle from an accepted input to `out_valid`. Throughput is 1 instruction per cycle with no hazard.
- A hazard costs exactly one bubble cycle; the instruction is accepted on the following cycle.
- Reset:
  - `out_valid`=0 and all `out_*` data and control are 0.
  - `in_ready`=1 the first cycle after reset is released.
  - Register contents are not reset, except x0.
- Reset asserted mid-stall drops the held instruction and returns the stage to the empty state.
- A write to x0 has no effect. A write together with a read of a different register has no interaction.

## Configuration
- `R200_ID_WB_BYPASS_EN` defined: a read of `wb_addr` while `wb_en` is asserted returns `wb_data` in the same cycle.
- Not defined: that same-address read/write instead raises `hazard` for one cycle, so the read happens after the write.

## Structure
- Package `r200_pkg` holds:
  - the opcode localparams;
  - the `wbsel_t` enum (ALU/MEM/PC4);
  - a `idex_t` struct for the stage register;
  - immediate-extraction functions parametrised by XLEN.
- One sub-module, `r200_gpr`, parametrised by XLEN and NREG: 2 read ports, 1 write port, and the bypass under the macro.

## Test plan
- Reset, then `in_valid`=1 with ADDI x5,x0,7 (0x00700293) → next cycle `out_valid`=1, op1=0, op2=7, rdaddr=5, regwr=1.
- LW x6,0(x5) followed by ADD x7,x6,x6 → exactly one bubble, `in_ready`=0 for one cycle, and ADD is emitted 2 cycles after LW.
- `out_ready`=0 for 3 cycles with a valid output held → outputs stable and `in_ready`=0; the held instruction is released on `out_ready`=1.
- `flush` coincident with a hazard and a valid input → next cycle `out_valid`=0, and the input is not consumed.
- `wb_en`=1, `wb_addr`=3, `wb_data`=0xDEAD with an incoming read of x3 → with the macro defined, op1=0xDEAD with no stall; without it, one bubble and then op1=0xDEAD.
- Opcode 0x7F → `out_illegal`=1 and all controls 0. BEQ at pc=0x100 with offset −4 → brtarg=0xFC, isbr=1.

Source files
------------

// File: rtl/r200_pkg.sv
// r200 decode-stage shared definitions: opcodes, writeback select,
// ID/EX control record and immediate extraction helpers.
package r200_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wbsel_t;

  // Control half of the ID/EX register; the XLEN-wide data fields live
  // beside it in the stage because a package struct cannot be parametrised.
  typedef struct packed {
    logic [4:0] rdaddr;
    logic [2:0] funct3;
    logic       regwr;
    logic       memwr;
    logic       isbr;
    logic       willjmp;
    logic       alu_cont;
    logic       illegal;
    logic       is_load;
    wbsel_t     wbsel;
  } idex_t;

  // Immediates are sign-extended to the widest supported XLEN (64);
  // callers narrow them with an XLEN'() cast.
  function automatic logic [63:0] imm_i(input logic [31:0] ins);
    return {{52{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [63:0] imm_s(input logic [31:0] ins);
    return {{52{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [63:0] imm_b(input logic [31:0] ins);
    return {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [63:0] imm_u(input logic [31:0] ins);
    return {{32{ins[31]}}, ins[31:12], 12'b0};
  endfunction

  function automatic logic [63:0] imm_j(input logic [31:0] ins);
    return {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/r200_gpr.sv
// r200 general-purpose register file: 2 combinational read ports, 1 write
// port, x0 hardwired to zero. Define R200_ID_WB_BYPASS_EN to forward a
// same-cycle write to the read ports.
module r200_gpr #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic [RA_W-1:0] ra1,
  input  logic [RA_W-1:0] ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NREG];
  logic            byp1, byp2;

`ifdef R200_ID_WB_BYPASS_EN
  assign byp1 = wb_en && (wb_addr == ra1);
  assign byp2 = wb_en && (wb_addr == ra2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Write port; entry 0 is never written so x0 stays architecturally zero.
  always_ff @(posedge clk) begin
    if (wb_en && (wb_addr != '0)) regs[wb_addr] <= wb_data;
  end

  // Read ports with x0 override and optional write forwarding.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : (byp1 ? wb_data : regs[ra1]);
    rd2 = (ra2 == '0) ? '0 : (byp2 ? wb_data : regs[ra2]);
  end

endmodule

// File: rtl/r200id_pipe.sv
// r200 pipelined instruction-decode stage with valid/ready handshakes,
// load-use stalling, flush and illegal-opcode flag.
// Option macro: R200_ID_WB_BYPASS_EN (writeback forwarding instead of stall).
module r200id_pipe import r200_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instrn,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_rs2v,
  output logic [XLEN-1:0] out_brtarg,
  output logic [RA_W-1:0] out_rdaddr,
  output logic [2:0]      out_funct3,
  output logic            out_regwr,
  output logic            out_memwr,
  output logic            out_isbr,
  output logic            out_willjmp,
  output logic            out_alu_cont,
  output logic            out_illegal,
  output logic [1:0]      out_wbsel
);

  logic [6:0]      opcode;
  logic [RA_W-1:0] rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0] rs1_v, rs2_v;

  idex_t           dec;
  logic [XLEN-1:0] d_op1, d_op2, d_rs2v, d_brtarg;
  logic            uses_rs2;

  idex_t           stage;
  logic [XLEN-1:0] s_pc, s_op1, s_op2, s_rs2v, s_brtarg;
  logic [RA_W-1:0] s_rd;

  logic            load_use, wb_conflict, hazard, advance, accept;

  assign opcode = in_instrn[6:0];
  assign rs1_a  = in_instrn[15 +: RA_W];
  assign rs2_a  = in_instrn[20 +: RA_W];
  assign rd_a   = in_instrn[7 +: RA_W];

  r200_gpr #(.XLEN(XLEN), .NREG(NREG)) u_gpr (
    .clk     (clk),
    .ra1     (rs1_a),
    .ra2     (rs2_a),
    .rd1     (rs1_v),
    .rd2     (rs2_v),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  // Opcode decode: operands, branch target and control for the incoming instruction.
  always_comb begin
    dec        = '0;
    dec.rdaddr = in_instrn[11:7];
    dec.funct3 = in_instrn[14:12];
    dec.wbsel  = WB_ALU;
    d_op1      = '0;
    d_op2      = '0;
    d_rs2v     = '0;
    d_brtarg   = '0;
    uses_rs2   = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_op1        = rs1_v;
        d_op2        = rs2_v;
        dec.regwr    = 1'b1;
        dec.alu_cont = in_instrn[30];
        uses_rs2     = 1'b1;
      end
      OPC_OPIMM: begin
        d_op1        = rs1_v;
        d_op2        = XLEN'(imm_i(in_instrn));
        dec.regwr    = 1'b1;
        dec.alu_cont = (in_instrn[14:12] == 3'b101) && in_instrn[30];
      end
      OPC_LOAD: begin
        d_op1       = rs1_v;
        d_op2       = XLEN'(imm_i(in_instrn));
        dec.regwr   = 1'b1;
        dec.is_load = 1'b1;
        dec.wbsel   = WB_MEM;
      end
      OPC_STORE: begin
        d_op1     = rs1_v;
        d_op2     = XLEN'(imm_s(in_instrn));
        d_rs2v    = rs2_v;
        dec.memwr = 1'b1;
        uses_rs2  = 1'b1;
      end
      OPC_BRANCH: begin
        d_op1    = rs1_v;
        d_op2    = rs2_v;
        d_brtarg = in_pc + XLEN'(imm_b(in_instrn));
        dec.isbr = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LUI: begin
        d_op1     = XLEN'(imm_u(in_instrn));
        dec.regwr = 1'b1;
      end
      OPC_JAL: begin
        d_brtarg    = in_pc + XLEN'(imm_j(in_instrn));
        dec.willjmp = 1'b1;
        dec.regwr   = 1'b1;
        dec.wbsel   = WB_PC4;
      end
      OPC_JALR: begin
        d_op1       = rs1_v;
        d_op2       = XLEN'(imm_i(in_instrn));
        dec.willjmp = 1'b1;
        dec.regwr   = 1'b1;
        dec.wbsel   = WB_PC4;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (rd_a == '0) dec.regwr = 1'b0;
  end

  assign s_rd = stage.rdaddr[RA_W-1:0];

  // Stall conditions: load-use against the held LOAD, and (without
  // forwarding) a read colliding with this cycle's writeback.
  always_comb begin
    load_use = out_valid && stage.is_load && (s_rd != '0) &&
               ((s_rd == rs1_a) || (uses_rs2 && (s_rd == rs2_a)));
`ifdef R200_ID_WB_BYPASS_EN
    wb_conflict = 1'b0;
`else
    wb_conflict = wb_en && (wb_addr != '0) &&
                  ((wb_addr == rs1_a) || (uses_rs2 && (wb_addr == rs2_a)));
`endif
    hazard   = in_valid && (load_use || wb_conflict);
    advance  = !out_valid || out_ready;
    in_ready = advance && !hazard && !flush;
    accept   = in_valid && in_ready;
  end

  // ID/EX register: reset, flush and non-accepting advances all load a
  // cleared bubble; a stalled output simply holds.
  always_ff @(posedge clk) begin
    if (!rst_n || flush || (advance && !accept)) begin
      out_valid <= 1'b0;
      stage     <= '0;
      s_pc      <= '0;
      s_op1     <= '0;
      s_op2     <= '0;
      s_rs2v    <= '0;
      s_brtarg  <= '0;
    end else if (advance) begin
      out_valid <= 1'b1;
      stage     <= dec;
      s_pc      <= in_pc;
      s_op1     <= d_op1;
      s_op2     <= d_op2;
      s_rs2v    <= d_rs2v;
      s_brtarg  <= d_brtarg;
    end
  end

  assign out_pc       = s_pc;
  assign out_op1      = s_op1;
  assign out_op2      = s_op2;
  assign out_rs2v     = s_rs2v;
  assign out_brtarg   = s_brtarg;
  assign out_rdaddr   = s_rd;
  assign out_funct3   = stage.funct3;
  assign out_regwr    = stage.regwr;
  assign out_memwr    = stage.memwr;
  assign out_isbr     = stage.isbr;
  assign out_willjmp  = stage.willjmp;
  assign out_alu_cont = stage.alu_cont;
  assign out_illegal  = stage.illegal;
  assign out_wbsel    = stage.wbsel;

endmodule

// File: tb/tb_r200id_pipe.sv
// Directed bench for r200id_pipe: decode vector table plus hand-written
// stall, backpressure, flush, writeback-collision and reset sequences.
module tb_r200id_pipe;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc = '0;
  logic [31:0]     in_instrn = '0;
  logic            flush = 1'b0;
  logic            wb_en = 1'b0;
  logic [RA_W-1:0] wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_pc, out_op1, out_op2, out_rs2v, out_brtarg;
  logic [RA_W-1:0] out_rdaddr;
  logic [2:0]      out_funct3;
  logic            out_regwr, out_memwr, out_isbr, out_willjmp;
  logic            out_alu_cont, out_illegal;
  logic [1:0]      out_wbsel;

  int n_cmp = 0;
  int n_err = 0;

  r200id_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instrn    (in_instrn),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_op1      (out_op1),
    .out_op2      (out_op2),
    .out_rs2v     (out_rs2v),
    .out_brtarg   (out_brtarg),
    .out_rdaddr   (out_rdaddr),
    .out_funct3   (out_funct3),
    .out_regwr    (out_regwr),
    .out_memwr    (out_memwr),
    .out_isbr     (out_isbr),
    .out_willjmp  (out_willjmp),
    .out_alu_cont (out_alu_cont),
    .out_illegal  (out_illegal),
    .out_wbsel    (out_wbsel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs2v;
    logic [31:0] brtarg;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  wbsel;
    logic [5:0]  ctl;   // {regwr, memwr, isbr, willjmp, alu_cont, illegal}
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  logic [5:0] act_ctl;

  initial begin
    //            name        ins           pc            op1           op2           rs2v          brtarg        rd  f3  wb  ctl
    vecs[0]  = '{"addi",    32'h00700293, 32'h00000000, 32'h00000000, 32'h00000007, 32'h0, 32'h0,         5'd5,  3'd0, 2'd0, 6'b100000};
    vecs[1]  = '{"add",     32'h002083B3, 32'h00000000, 32'h00000064, 32'hFFFFFFFC, 32'h0, 32'h0,         5'd7,  3'd0, 2'd0, 6'b100000};
    vecs[2]  = '{"sub",     32'h40308433, 32'h00000000, 32'h00000064, 32'h00000005, 32'h0, 32'h0,         5'd8,  3'd0, 2'd0, 6'b100010};
    vecs[3]  = '{"srai",    32'h4040D493, 32'h00000000, 32'h00000064, 32'h00000404, 32'h0, 32'h0,         5'd9,  3'd5, 2'd0, 6'b100010};
    vecs[4]  = '{"lw",      32'h0080A303, 32'h00000000, 32'h00000064, 32'h00000008, 32'h0, 32'h0,         5'd6,  3'd2, 2'd1, 6'b100000};
    vecs[5]  = '{"sw",      32'hFE20AE23, 32'h00000000, 32'h00000064, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,  5'd28, 3'd2, 2'd0, 6'b010000};
    vecs[6]  = '{"beq",     32'hFE308EE3, 32'h00000100, 32'h00000064, 32'h00000005, 32'h0, 32'h000000FC,  5'd29, 3'd0, 2'd0, 6'b001000};
    vecs[7]  = '{"lui",     32'h12345537, 32'h00000000, 32'h12345000, 32'h00000000, 32'h0, 32'h0,         5'd10, 3'd5, 2'd0, 6'b100000};
    vecs[8]  = '{"jal",     32'h008000EF, 32'h00000200, 32'h00000000, 32'h00000000, 32'h0, 32'h00000208,  5'd1,  3'd0, 2'd2, 6'b100100};
    vecs[9]  = '{"jal_wrap",32'hFF9FF06F, 32'h00000004, 32'h00000000, 32'h00000000, 32'h0, 32'hFFFFFFFC,  5'd0,  3'd7, 2'd2, 6'b000100};
    vecs[10] = '{"jalr",    32'h00C100E7, 32'h00000000, 32'hFFFFFFFC, 32'h0000000C, 32'h0, 32'h0,         5'd1,  3'd0, 2'd2, 6'b100100};
    vecs[11] = '{"illegal", 32'h0000007F, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0, 32'h0,         5'd0,  3'd0, 2'd0, 6'b000001};
    vecs[12] = '{"addi_x0", 32'h00108013, 32'h00000000, 32'h00000064, 32'h00000001, 32'h0, 32'h0,         5'd0,  3'd0, 2'd0, 6'b000000};
    vecs[13] = '{"add_x0x0",32'h000005B3, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0, 32'h0,         5'd11, 3'd0, 2'd0, 6'b100000};

    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op1", out_op1, 0);
    chk("rst_brtarg", out_brtarg, 0);
    chk("rst_regwr", out_regwr, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Register preload, including an ignored write to x0
    wb_write(5'd1, 32'h00000064);
    wb_write(5'd2, 32'hFFFFFFFC);
    wb_write(5'd3, 32'h00000005);
    wb_write(5'd0, 32'h00000055);

    // Decode table
    for (int i = 0; i < 14; i++) begin
      in_instrn = vecs[i].ins;
      in_pc     = vecs[i].pc;
      in_valid  = 1'b1;
      #1;
      chk({vecs[i].name, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      act_ctl = {out_regwr, out_memwr, out_isbr, out_willjmp, out_alu_cont, out_illegal};
      chk({vecs[i].name, "_valid"}, out_valid, 1);
      chk({vecs[i].name, "_pc"}, out_pc, vecs[i].pc);
      chk({vecs[i].name, "_op1"}, out_op1, vecs[i].op1);
      chk({vecs[i].name, "_op2"}, out_op2, vecs[i].op2);
      chk({vecs[i].name, "_rs2v"}, out_rs2v, vecs[i].rs2v);
      chk({vecs[i].name, "_brtarg"}, out_brtarg, vecs[i].brtarg);
      chk({vecs[i].name, "_rd"}, out_rdaddr, vecs[i].rd);
      chk({vecs[i].name, "_f3"}, out_funct3, vecs[i].f3);
      chk({vecs[i].name, "_wbsel"}, out_wbsel, vecs[i].wbsel);
      chk({vecs[i].name, "_ctl"}, act_ctl, vecs[i].ctl);
      tick();
      chk({vecs[i].name, "_drain"}, out_valid, 0);
    end

    // Load-use: LW x6,0(x5) then ADD x7,x6,x6
    in_pc = 32'h0; in_instrn = 32'h0002A303; in_valid = 1'b1;
    tick();
    chk("lu_lw_valid", out_valid, 1);
    chk("lu_lw_wbsel", out_wbsel, 1);
    in_instrn = 32'h006303B3;
    #1;
    chk("lu_in_ready_stall", in_ready, 0);
    tick();
    chk("lu_bubble", out_valid, 0);
    chk("lu_in_ready_after", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("lu_add_valid", out_valid, 1);
    chk("lu_add_rd", out_rdaddr, 7);
    tick();

    // Backpressure: hold ADDI for 3 cycles, then release onto LUI
    out_ready = 1'b0;
    in_instrn = 32'h00700293; in_valid = 1'b1;
    tick();
    chk("bp_valid", out_valid, 1);
    in_instrn = 32'h12345537;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_op2", out_op2, 7);
      chk("bp_hold_rd", out_rdaddr, 5);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_op1", out_op1, 32'h12345000);
    tick();

    // Flush coincident with a load-use hazard and a valid input
    in_instrn = 32'h0002A303; in_valid = 1'b1;
    tick();
    in_instrn = 32'h006303B3; flush = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("fl_add_valid", out_valid, 1);
    chk("fl_add_rd", out_rdaddr, 7);
    tick();

    // Writeback collision: ADDI x12,x3,0 while x3 <= 0xDEAD
    in_instrn = 32'h00018613; in_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000DEAD;
`ifdef R200_ID_WB_BYPASS_EN
    #1;
    chk("wb_in_ready", in_ready, 1);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("wb_valid", out_valid, 1);
    chk("wb_op1", out_op1, 32'h0000DEAD);
`else
    #1;
    chk("wb_in_ready", in_ready, 0);
    tick();
    wb_en = 1'b0;
    chk("wb_bubble", out_valid, 0);
    #1;
    chk("wb_in_ready_after", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("wb_valid", out_valid, 1);
    chk("wb_op1", out_op1, 32'h0000DEAD);
`endif
    tick();

    // Reset during a stall drops the held instruction
    out_ready = 1'b0;
    in_instrn = 32'h00700293; in_valid = 1'b1;
    tick();
    chk("rs_held_valid", out_valid, 1);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("rs_valid", out_valid, 0);
    chk("rs_op2", out_op2, 0);
    chk("rs_regwr", out_regwr, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("rs_in_ready", in_ready, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
